adder_rr_scheduler: RTL and testbench

//  Time-shares one signed WIDTH-bit adder between NUM_REQ requesters (DCT/quantiser stages).

---
 rtl/adder_rr_scheduler_pkg.sv | 24 ++
 rtl/adder_rr_scheduler_full_adder.sv | 18 +
 rtl/adder_rr_scheduler_rr_arbiter.sv | 61 ++++++
 rtl/adder_rr_scheduler.sv | 95 +++++++++
 tb/tb_adder_rr_scheduler.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_rr_scheduler_pkg.sv
// Shared defaults and helpers for the round-robin shared-adder scheduler.
// The requester-index width is derived here so the top and bench agree on it.
package adder_rr_scheduler_pkg;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_NUM_REQ = 4;

    // Bits needed to index n items; never returns less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v != 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_rr_scheduler_full_adder.sv
// Signed WIDTH-bit adder producing a WIDTH+1-bit result, so overflow cannot occur.
// This is the single arithmetic resource shared by every requester.
module adder_rr_scheduler_full_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_sum
);

    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_b_ext;

    assign w_a_ext = {i_a[WIDTH-1], i_a};
    assign w_b_ext = {i_b[WIDTH-1], i_b};
    assign o_sum   = w_a_ext + w_b_ext;

endmodule

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: rotate requests so i_ptr lands at bit 0, priority-encode the
// lowest set bit, then rotate the winning offset back into an absolute requester index.
module adder_rr_scheduler_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx
);

    logic [NUM_REQ-1:0] w_req_rot;
    logic               w_found;
    logic [ID_W-1:0]    w_off;
    logic [ID_W:0]      w_abs;
    logic [ID_W-1:0]    w_idx;

    // Mux of constant rotations keeps every bit select static.
    always_comb begin
        w_req_rot = i_req;
        for (int p = 0; p < NUM_REQ; p++) begin
            if (i_ptr == ID_W'(p)) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    w_req_rot[k] = i_req[(p + k) % NUM_REQ];
                end
            end
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_found = 1'b1;
                w_off   = ID_W'(k);
            end
        end
    end

    always_comb begin
        w_abs = {1'b0, w_off} + {1'b0, i_ptr};
        if (w_abs >= (ID_W + 1)'(NUM_REQ)) begin
            w_idx = w_abs[ID_W-1:0] - ID_W'(NUM_REQ);
        end else begin
            w_idx = w_abs[ID_W-1:0];
        end
    end

    always_comb begin
        o_gnt = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            o_gnt[k] = i_en && w_found && (w_idx == ID_W'(k));
        end
    end

    assign o_idx = w_idx;

endmodule

// File: rtl/adder_rr_scheduler.sv
// Time-shares one signed adder between NUM_REQ requesters with round-robin grants and a
// single tagged result slot; a drain and a refill may happen on the same edge.
module adder_rr_scheduler
    import adder_rr_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH:0]           res_sum,
    output logic [ID_W-1:0]          res_id
);

    logic               r_res_valid;
    logic [WIDTH:0]     r_res_sum;
    logic [ID_W-1:0]    r_res_id;
    logic [ID_W-1:0]    r_rr_ptr;

    logic               w_can_accept;
    logic               w_arb_en;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_idx;
    logic               w_transfer;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic [WIDTH:0]     w_sum;

    assign w_can_accept = !r_res_valid || res_ready;
    // Holding grants low during reset keeps a request from seeing a stray accept.
    assign w_arb_en     = w_can_accept && !rst;

    adder_rr_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arbiter (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_transfer = |w_gnt;
    assign w_ptr_nxt  = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == ID_W'(i)) begin
                w_op_a = req_a[i*WIDTH +: WIDTH];
                w_op_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    adder_rr_scheduler_full_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a   (w_op_a),
        .i_b   (w_op_b),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_transfer) begin
            r_res_valid <= 1'b1;
            r_res_sum   <= w_sum;
            r_res_id    <= w_idx;
            r_rr_ptr    <= w_ptr_nxt;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign req_ready = w_gnt;
    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_id    = r_res_id;

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Bench for adder_rr_scheduler: directed scenarios plus randomized traffic checked
// against a queue-free behavioural model of the grant/result rules.
module tb_adder_rr_scheduler;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic           res_ready;
    logic [W:0]     res_sum;
    logic [1:0]     res_id;

    int   n_checks = 0;
    int   n_fails  = 0;

    // Reference state: slot contents and the next requester to search from.
    logic m_valid = 1'b0;
    int   m_sum   = 0;
    int   m_id    = 0;
    int   m_ptr   = 0;

    always #5 clk = ~clk;

    adder_rr_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id)
    );

    function automatic logic [N-1:0] model_grant(input logic r, input logic [N-1:0] rv,
                                                 input logic rr);
        logic [N-1:0] g;
        int           i;
        g = '0;
        if (r || (m_valid && !rr)) return g;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (rv[i] && g == '0) g[i] = 1'b1;
        end
        return g;
    endfunction

    task automatic model_update(input logic r, input logic [N*W-1:0] pa,
                                input logic [N*W-1:0] pb, input logic rr, input logic [N-1:0] g);
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        if (r) begin
            m_valid = 1'b0;
            m_sum   = 0;
            m_id    = 0;
            m_ptr   = 0;
        end else if (g != '0) begin
            for (int k = 0; k < N; k++) begin
                if (g[k]) begin
                    sa    = W'(pa >> (k * W));
                    sb    = W'(pb >> (k * W));
                    m_sum = int'(sa) + int'(sb);
                    m_id  = k;
                    m_ptr = (k + 1) % N;
                end
            end
            m_valid = 1'b1;
        end else if (rr) begin
            m_valid = 1'b0;
        end
    endtask

    function automatic logic [N*W-1:0] pack4(input int e0, input int e1, input int e2,
                                             input int e3);
        return {W'(e3), W'(e2), W'(e1), W'(e0)};
    endfunction

    // Drives one cycle from a falling edge and returns at the next falling edge.
    task automatic run_cycle(input logic r, input logic [N-1:0] rv, input logic [N*W-1:0] pa,
                             input logic [N*W-1:0] pb, input logic rr,
                             output logic [N-1:0] o_rdy, output logic [N-1:0] e_rdy);
        rst       = r;
        req_valid = rv;
        req_a     = pa;
        req_b     = pb;
        res_ready = rr;
        #1;
        o_rdy = req_ready;
        e_rdy = model_grant(r, rv, rr);
        @(posedge clk);
        model_update(r, pa, pb, rr, e_rdy);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [N-1:0] rdy, erdy;
        for (int c = 0; c < 2; c++) begin
            run_cycle(1'b1, '1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, rdy, erdy);
            n_checks++;
            if (rdy !== 4'b0000) begin
                n_fails++;
                $display("FAIL reset_ready cyc=%0d got=%b exp=0000", c, rdy);
            end
        end
        n_checks++;
        if (res_valid !== 1'b0 || res_sum !== 9'd0 || res_id !== 2'd0) begin
            n_fails++;
            $display("FAIL reset_state got v=%b sum=%h id=%0d exp v=0 sum=000 id=0",
                     res_valid, res_sum, res_id);
        end
    endtask

    task automatic test_single();
        logic [N-1:0] rdy, erdy;
        run_cycle(1'b0, 4'b0100, pack4(0, 0, 5, 0), pack4(0, 0, -3, 0), 1'b1, rdy, erdy);
        n_checks++;
        if (rdy !== 4'b0100) begin
            n_fails++;
            $display("FAIL single_ready got=%b exp=0100", rdy);
        end
        n_checks++;
        if (res_valid !== 1'b1 || $signed(res_sum) !== 9'sd2 || res_id !== 2'd2) begin
            n_fails++;
            $display("FAIL single_result got v=%b sum=%0d id=%0d exp v=1 sum=2 id=2",
                     res_valid, $signed(res_sum), res_id);
        end
        run_cycle(1'b0, 4'b0000, '0, '0, 1'b1, rdy, erdy);
        n_checks++;
        if (res_valid !== 1'b0 || $signed(res_sum) !== 9'sd2 || res_id !== 2'd2) begin
            n_fails++;
            $display("FAIL drain_hold got v=%b sum=%0d id=%0d exp v=0 sum=2 id=2",
                     res_valid, $signed(res_sum), res_id);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] rdy, erdy, want;
        run_cycle(1'b1, '0, '0, '0, 1'b1, rdy, erdy);
        for (int c = 0; c < 8; c++) begin
            run_cycle(1'b0, '1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, rdy, erdy);
            want = 4'b0001 << (c % N);
            n_checks++;
            if (rdy !== want) begin
                n_fails++;
                $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, rdy, want);
            end
            n_checks++;
            if (res_valid !== 1'b1 || int'($signed(res_sum)) != m_sum || res_id !== 2'(c % N))
            begin
                n_fails++;
                $display("FAIL rr_result cyc=%0d got v=%b sum=%0d id=%0d exp v=1 sum=%0d id=%0d",
                         c, res_valid, $signed(res_sum), res_id, m_sum, c % N);
            end
        end
    endtask

    task automatic test_arith();
        logic [N-1:0] rdy, erdy;
        run_cycle(1'b0, 4'b0001, pack4(-128, 0, 0, 0), pack4(-128, 0, 0, 0), 1'b1, rdy, erdy);
        n_checks++;
        if (res_sum !== 9'h100 || res_id !== 2'd0) begin
            n_fails++;
            $display("FAIL arith_min got sum=%h id=%0d exp sum=100 id=0", res_sum, res_id);
        end
        run_cycle(1'b0, 4'b0001, pack4(127, 0, 0, 0), pack4(127, 0, 0, 0), 1'b1, rdy, erdy);
        n_checks++;
        if (res_sum !== 9'h0FE) begin
            n_fails++;
            $display("FAIL arith_max got sum=%h exp sum=0fe", res_sum);
        end
    endtask

    task automatic test_stall();
        logic [N-1:0] rdy, erdy, want;
        logic [W:0]   held_sum;
        logic [1:0]   held_id;
        run_cycle(1'b0, '1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, rdy, erdy);
        held_sum = res_sum;
        held_id  = res_id;
        for (int c = 0; c < 3; c++) begin
            run_cycle(1'b0, '1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, rdy, erdy);
            n_checks++;
            if (rdy !== 4'b0000 || res_valid !== 1'b1 || res_sum !== held_sum ||
                res_id !== held_id) begin
                n_fails++;
                $display("FAIL stall_hold cyc=%0d got rdy=%b v=%b sum=%h id=%0d exp rdy=0000 v=1 sum=%h id=%0d",
                         c, rdy, res_valid, res_sum, res_id, held_sum, held_id);
            end
        end
        run_cycle(1'b0, '1, pack4(10, 20, 30, 40), pack4(1, 2, 3, 4), 1'b1, rdy, erdy);
        want = 4'b0001 << ((int'(held_id) + 1) % N);
        n_checks++;
        if (rdy !== want || res_valid !== 1'b1 || int'($signed(res_sum)) != m_sum) begin
            n_fails++;
            $display("FAIL stall_resume got rdy=%b v=%b sum=%0d exp rdy=%b v=1 sum=%0d",
                     rdy, res_valid, $signed(res_sum), want, m_sum);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] rdy, erdy;
        run_cycle(1'b0, 4'b0100, pack4(0, 0, 9, 0), pack4(0, 0, 9, 0), 1'b1, rdy, erdy);
        run_cycle(1'b1, '1, '0, '0, 1'b0, rdy, erdy);
        n_checks++;
        if (rdy !== 4'b0000 || res_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL midreset got rdy=%b v=%b exp rdy=0000 v=0", rdy, res_valid);
        end
        run_cycle(1'b0, '1, pack4(3, 0, 0, 0), pack4(4, 0, 0, 0), 1'b0, rdy, erdy);
        n_checks++;
        if (rdy !== 4'b0001 || res_id !== 2'd0 || $signed(res_sum) !== 9'sd7) begin
            n_fails++;
            $display("FAIL midreset_grant got rdy=%b id=%0d sum=%0d exp rdy=0001 id=0 sum=7",
                     rdy, res_id, $signed(res_sum));
        end
    endtask

    task automatic test_random();
        logic [N-1:0] rdy, erdy, rv;
        logic         r, rr, acc;
        int           wait_cnt [N];
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            rv  = N'($urandom_range(0, 15));
            rr  = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 63) == 0);
            acc = !r && (!m_valid || rr);
            run_cycle(r, rv, {$urandom, $urandom}, {$urandom, $urandom}, rr, rdy, erdy);
            n_checks++;
            if (rdy !== erdy) begin
                n_fails++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, rdy, erdy);
            end
            n_checks++;
            if (res_valid !== m_valid || int'($signed(res_sum)) != m_sum || res_id !== 2'(m_id))
            begin
                n_fails++;
                $display("FAIL rand_result cyc=%0d got v=%b sum=%0d id=%0d exp v=%b sum=%0d id=%0d",
                         c, res_valid, $signed(res_sum), res_id, m_valid, m_sum, m_id);
            end
            for (int i = 0; i < N; i++) begin
                if (r || !rv[i] || rdy[i]) begin
                    wait_cnt[i] = 0;
                end else if (acc) begin
                    wait_cnt[i]++;
                    n_checks++;
                    if (wait_cnt[i] >= N) begin
                        n_fails++;
                        $display("FAIL fairness cyc=%0d req=%0d waited=%0d limit=%0d",
                                 c, i, wait_cnt[i], N - 1);
                    end
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_arith();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
